can_reg_access_arbiter: RTL

- Arbitrates and sequences all accesses to the CAN controller's bank of 8-bit configuration and status registers.
- Two requesters share the bank: the host bus interface (read/write) and the internal CAN core (write-only status updates, e.g. error capture and arbitration-lost capture).
- Drives per-register write enables and shared write data into the register instances, and returns read data to the host.
- Enforces the reset-mode write lock on configuration registers.

---
 rtl/can_reg_access_arbiter.sv | 128 ++++++++++++
 1 files changed

// File: rtl/can_reg_access_arbiter.sv
// Round-robin arbiter sequencing host/core accesses to the CAN register bank (CAN_ARB_CORE_PRIORITY_EN: core fixed priority).
// Latency: reg_we in the cycle after req is sampled, ack one cycle later, then one IDLE cycle.
// Backpressure: requesters hold req until their one-cycle ack; the loser of a tie waits in IDLE.
module can_reg_access_arbiter #(
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 32,
    parameter int CFG_LAST = 7
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       reset_mode,
    input  logic                       h_req,
    input  logic                       h_we,
    input  logic [ADDR_W-1:0]          h_addr,
    input  logic [DATA_W-1:0]          h_wdata,
    output logic                       h_ack,
    output logic                       h_err,
    output logic [DATA_W-1:0]          h_rdata,
    input  logic                       c_req,
    input  logic [ADDR_W-1:0]          c_addr,
    input  logic [DATA_W-1:0]          c_wdata,
    output logic                       c_ack,
    output logic [NUM_REGS-1:0]        reg_we,
    output logic [DATA_W-1:0]          reg_wdata,
    input  logic [NUM_REGS*DATA_W-1:0] reg_rdata,
    output logic                       busy
);

    typedef enum logic [1:0] {IDLE, GNT_H, GNT_C, ACK} state_t;

    localparam logic [ADDR_W:0] NREGS = (ADDR_W+1)'(NUM_REGS);
    localparam logic [ADDR_W:0] CFG_L = (ADDR_W+1)'(CFG_LAST);

    state_t              state;
    logic                last_grant;   // 1 = core was granted last
    logic                acc_ok;
    logic                acc_rd;
    logic                acc_err;
    logic [ADDR_W-1:0]   acc_addr;

    logic                pick_host;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic                addr_ok;
    logic                is_cfg;
    logic                wr_ok;
    logic                host_err;
    logic [NUM_REGS-1:0] we_dec;
    logic [DATA_W-1:0]   rd_sel;

    always_comb begin
`ifdef CAN_ARB_CORE_PRIORITY_EN
        pick_host = h_req && !c_req;
`else
        pick_host = h_req && (!c_req || last_grant);
`endif
        sel_addr  = pick_host ? h_addr  : c_addr;
        sel_wdata = pick_host ? h_wdata : c_wdata;
        addr_ok   = {1'b0, sel_addr} < NREGS;
        is_cfg    = {1'b0, sel_addr} <= CFG_L;
        // The core may never touch configuration registers; the host only in reset mode.
        wr_ok     = addr_ok && (pick_host ? (h_we && (!is_cfg || reset_mode)) : !is_cfg);
        host_err  = !addr_ok || (h_we && is_cfg && !reset_mode);
        we_dec    = '0;
        rd_sel    = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            we_dec[i] = wr_ok && (sel_addr == ADDR_W'(i));
            if (acc_addr == ADDR_W'(i))
                rd_sel = reg_rdata[i*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            reg_we     <= '0;
            reg_wdata  <= '0;
            h_ack      <= 1'b0;
            h_err      <= 1'b0;
            h_rdata    <= '0;
            c_ack      <= 1'b0;
            busy       <= 1'b0;
            acc_ok     <= 1'b0;
            acc_rd     <= 1'b0;
            acc_err    <= 1'b0;
            acc_addr   <= '0;
        end else begin
            reg_we <= '0;
            h_ack  <= 1'b0;
            c_ack  <= 1'b0;
            case (state)
                IDLE: begin
                    if (h_req || c_req) begin
                        state      <= pick_host ? GNT_H : GNT_C;
                        last_grant <= !pick_host;
                        reg_we     <= we_dec;
                        reg_wdata  <= sel_wdata;
                        busy       <= 1'b1;
                        acc_ok     <= addr_ok;
                        acc_rd     <= pick_host && !h_we;
                        acc_err    <= host_err;
                        acc_addr   <= sel_addr;
                    end
                end
                GNT_H: begin
                    state <= ACK;
                    h_ack <= 1'b1;
                    h_err <= acc_err;
                    if (!acc_ok)
                        h_rdata <= '0;
                    else if (acc_rd)
                        h_rdata <= rd_sel;
                end
                GNT_C: begin
                    state <= ACK;
                    c_ack <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
